// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe register pipeline: mode encoding and
// scan-chain length helper.
package dff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD  = 2'd0;
  localparam mode_t MODE_LOAD  = 2'd1;
  localparam mode_t MODE_FLUSH = 2'd2;
  localparam mode_t MODE_SCAN  = 2'd3;

  // Every stage contributes its data bits plus its valid bit to the chain.
  function automatic int unsigned scan_len(input int unsigned width,
                                           input int unsigned depth);
    return depth * (width + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with parallel load,
// flush, hold and a serial scan path running data[0] -> data[W-1] -> vld.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_t            mode,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             vld_in,
  input  logic             scan_in,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  output logic             scan_out
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    case (mode)
      MODE_SCAN: begin
        {vld_d, data_d} = {data_q, scan_in};
      end
      MODE_LOAD: begin
        data_d = data_in;
        vld_d  = vld_in;
      end
      MODE_FLUSH: begin
        // Flush only invalidates; data keeps moving when enabled.
        vld_d = 1'b0;
        if (en) data_d = data_in;
      end
      default: begin
        data_d = data_q;
        vld_d  = vld_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out = data_q;
  assign vld_out  = vld_q;
  assign scan_out = vld_q;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH register pipeline with clock enable, valid tracking,
// synchronous flush and a single full-scan chain through every bit.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic             SE,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_IN,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_OUT,
  output logic             SO
);

  mode_t mode;

  // Scan overrides flush, flush overrides enable.
  always_comb begin
    if (SE)         mode = MODE_SCAN;
    else if (FLUSH) mode = MODE_FLUSH;
    else if (EN)    mode = MODE_LOAD;
    else            mode = MODE_HOLD;
  end

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic             stage_vld  [DEPTH];
  logic             stage_so   [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] par_data;
    logic             par_vld;
    logic             scan_bit;

    if (k == 0) begin : g_head
      assign par_data = D;
      assign par_vld  = VLD_IN;
      assign scan_bit = SI;
    end else begin : g_body
      assign par_data = stage_data[k-1];
      assign par_vld  = stage_vld[k-1];
      assign scan_bit = stage_so[k-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (CLK),
      .rst      (RST),
      .mode     (mode),
      .en       (EN),
      .data_in  (par_data),
      .vld_in   (par_vld),
      .scan_in  (scan_bit),
      .data_out (stage_data[k]),
      .vld_out  (stage_vld[k]),
      .scan_out (stage_so[k])
    );
  end

  assign Q       = stage_data[DEPTH-1];
  assign VLD_OUT = stage_vld[DEPTH-1];
  assign SO      = stage_so[DEPTH-1];

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised multi-stage register pipeline with asynchronous reset, clock enable, valid tracking, synchronous flush and a full-scan shift mode. It is the generalised successor of the single-bit DFF cell: one instance replaces a WIDTH x DEPTH array of hand-placed flops in datapath retiming and delay lines. It also makes every bit observable and controllable through one serial scan chain for ATPG and bring-up.

## Interface
- WIDTH, default 8: data bits per stage, 1 or more.
- DEPTH, default 4: number of stages, 1 or more; this is the latency in enabled cycles.
- RESET_VAL, default 0: WIDTH-bit value loaded into every data stage on reset.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous and active-high.
- EN  in  1  advance enable for normal mode.
- FLUSH  in  1  synchronous clear of all valid bits.
- SE  in  1  scan enable; selects scan-shift mode.
- SI  in  1  scan data in.
- D  in  WIDTH  pipeline data in.
- VLD_IN  in  1  D is valid.
- Q  out  WIDTH  data of the last stage (registered).
- VLD_OUT  out  1  valid bit of the last stage (registered).
- SO  out  1  scan data out.

## Operation
- State: DEPTH stages. Each stage holds data[WIDTH-1:0] and vld. Stage 0 is the input end; stage DEPTH-1 drives Q and VLD_OUT.
- Mode priority per edge: RST, then SE, then FLUSH, then EN, then hold.
- RST asserted: every data register becomes RESET_VAL and every vld becomes 0, immediately and without waiting for CLK. Q = RESET_VAL, VLD_OUT = 0, SO = 0 while RST is high. All other inputs are ignored while RST is high.
- SCAN (SE=1): the whole state shifts one position per edge along a chain of length L = DEPTH*(WIDTH+1):
  - SI goes into stage0.data[0].
  - stage k.data[i] moves to stage k.data[i+1].
  - stage k.data[WIDTH-1] moves to stage k.vld.
  - stage k.vld moves to stage k+1.data[0].
  - SO = stage DEPTH-1.vld.
  - EN, FLUSH, D and VLD_IN are ignored.
- FLUSH (SE=0, FLUSH=1): all vld bits become 0 and VLD_IN for that edge is dropped. Data registers advance if EN=1 and otherwise hold. Data is not cleared.
- LOAD (SE=0, FLUSH=0, EN=1): stage0 takes {D, VLD_IN}; stage k takes stage k-1 for k ≥ 1.
- HOLD (SE=0, FLUSH=0, EN=0): all state unchanged.
- Invalid data still propagates. vld is informational only and never gates data movement.
- DEPTH=1: stage 0 is also the last stage, so Q follows D one enabled edge later.

## Timing
- Latency: a D sampled at enabled edge n appears on Q after edge n+DEPTH-1, counting only enabled edges. With EN held high, Q is valid DEPTH cycles after D.
- Outputs come straight from flops; there is no combinational path from any input to Q, VLD_OUT or SO.
- Reset release: the first edge with RST low is a normal mode-priority edge. RST asserted mid-scan or mid-stream discards all contents.
- SE toggling: the mode is sampled per edge. Leaving scan mode resumes LOAD/HOLD on the shifted-in contents with no extra cycle.
- A full scan unload or load takes exactly L edges. SO shows the old stage DEPTH-1.vld first, then stage DEPTH-1.data[WIDTH-1] down to data[0], then stage DEPTH-2.vld, and so on.

## Structure
- Shared package dff_pkg:
  - mode encoding constants MODE_HOLD, MODE_LOAD, MODE_FLUSH, MODE_SCAN (2 bits).
  - a function computing the scan length L from WIDTH and DEPTH.
- A single mode decoder in the top level computes the mode from SE/FLUSH/EN; it is shared by all stages.
- Sub-module dff_stage: one (WIDTH+1)-bit stage with async reset and a per-mode next-state mux.
  - Inputs: parallel-in from the previous stage, scan-in bit from the previous stage, and the mode.
  - Outputs: data, vld and scan-out bit.
- The top level is a generate loop of DEPTH dff_stage instances plus the output taps.

## Test plan
- Reset: drive RST=1 mid-cycle with WIDTH=8, DEPTH=4, RESET_VAL=8'hA5. Q must be 8'hA5 and VLD_OUT 0 before the next CLK edge. After release with EN=0, the outputs must hold for 3 edges.
- Streaming: EN=1, VLD_IN=1, D = 1,2,3,… on consecutive edges. Q must equal 1 on the 4th edge, then increment each cycle, with VLD_OUT=1 from the 4th edge onward.
- Stall: during streaming, drop EN for 2 cycles. Q and VLD_OUT must freeze for exactly those 2 cycles, then resume the sequence with no value lost or duplicated.
- Flush: with 4 valid entries in flight, pulse FLUSH=1 with EN=1 and VLD_IN=1. Next cycle VLD_OUT=0 and all stages are invalid. The data pattern on Q must keep advancing.
- Scan round-trip: with DEPTH=2, WIDTH=3 (L=8), shift in 8'b1011_0010 with SE=1 for 8 edges, then shift out 8 more edges. SO must reproduce the same bit sequence. Parallel outputs must match the loaded chain positions.
- Priority: SE=1 with FLUSH=1 and EN=1 must perform a pure scan shift with vld bits not cleared. Asserting RST during scan must zero SO immediately.
